// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared state enum, widths and saturation helpers for the requant drain path
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package npu_pkg;

  localparam int Q_DATA_WIDTH = `DATA_WIDTH;
  localparam int Q_ACC_WIDTH  = `ACC_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  function automatic longint sat_max(input int dw);
    return (longint'(1) << (dw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - round-shift, optional ReLU (QUANT_RELU_EN) and saturation of one accumulator element
module requant_lane
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH  = Q_DATA_WIDTH,
  parameter int ACC_WIDTH   = Q_ACC_WIDTH,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [DATA_WIDTH-1:0]  q
);

  // One extra bit so adding the rounding half can never overflow.
  localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH + 1)'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH:0] MIN_V = (ACC_WIDTH + 1)'(sat_min(DATA_WIDTH));

  logic signed [ACC_WIDTH:0] ext;
  logic signed [ACC_WIDTH:0] half;
  logic signed [ACC_WIDTH:0] rnd;
  logic signed [ACC_WIDTH:0] r;

  // Round half up, arithmetic shift, then clamp into the output range.
  always_comb begin
    ext  = {acc[ACC_WIDTH-1], acc};
    half = '0;
    if (shift != '0) begin
      half = (ACC_WIDTH + 1)'(1) << (shift - SHIFT_WIDTH'(1));
    end
    rnd = ext + half;
    r   = (shift == '0) ? ext : (rnd >>> shift);
`ifdef QUANT_RELU_EN
    if (r[ACC_WIDTH]) begin
      r = '0;
    end
`endif
    if (r > MAX_V) begin
      q = MAX_V[DATA_WIDTH-1:0];
    end else if (r < MIN_V) begin
      q = MIN_V[DATA_WIDTH-1:0];
    end else begin
      q = r[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/requant_drain_ctrl.sv
// rtl/requant_drain_ctrl.sv - drains accumulators, requantizes and packs them onto the output stream (QUANT_RELU_EN selects fused ReLU)
module requant_drain_ctrl
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH  = Q_DATA_WIDTH,
  parameter int ACC_WIDTH   = Q_ACC_WIDTH,
  parameter int PACK        = 4,
  parameter int LEN_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
  input  logic [SHIFT_WIDTH-1:0]     cfg_shift,
  input  logic                       acc_valid,
  input  logic [ACC_WIDTH-1:0]       acc_data,
  output logic                       acc_ready,
  output logic                       out_valid,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int WW = PACK * DATA_WIDTH;

  state_t                 state;
  state_t                 state_next;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [PW-1:0]          pack_cnt;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [WW-1:0]          pack_buf;
  logic [WW-1:0]          next_word;
  logic [DATA_WIDTH-1:0]  lane_q;
  logic                   last_elem;
  logic                   word_completes;
  logic                   acc_fire;
  logic                   out_fire;

  assign last_elem      = (remaining == LEN_WIDTH'(1));
  assign word_completes = (pack_cnt == PW'(PACK - 1)) || last_elem;
  assign acc_fire       = acc_valid && acc_ready;
  assign out_fire       = out_valid && out_ready;
  assign busy           = (state != IDLE);

  requant_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_lane (
    .acc  (acc_data),
    .shift(shift_q),
    .q    (lane_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and accept gating; a completing element waits while the out register is stuck.
  always_comb begin
    state_next = state;
    acc_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (cfg_len != '0)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        acc_ready = !(word_completes && out_valid && !out_ready);
        if (acc_valid && !(word_completes && out_valid && !out_ready) && last_elem) begin
          state_next = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (out_fire && out_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Current pack buffer with the incoming element dropped into its lane.
  always_comb begin
    next_word = pack_buf;
    for (int i = 0; i < PACK; i++) begin
      if (pack_cnt == PW'(i)) begin
        next_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_q;
      end
    end
  end

  // Counters, pack buffer, output register and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      pack_cnt  <= '0;
      shift_q   <= '0;
      pack_buf  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && start) begin
        remaining <= cfg_len;
        shift_q   <= cfg_shift;
        pack_cnt  <= '0;
        pack_buf  <= '0;
        done      <= (cfg_len == '0);
      end
      if (acc_fire) begin
        remaining <= remaining - LEN_WIDTH'(1);
        if (word_completes) begin
          pack_cnt <= '0;
          pack_buf <= '0;
        end else begin
          pack_cnt <= pack_cnt + PW'(1);
          pack_buf <= next_word;
        end
      end
      if (acc_fire && word_completes) begin
        out_valid <= 1'b1;
        out_data  <= next_word;
        out_last  <= last_elem;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if ((state == WAIT_OUT) && out_fire && out_last) begin
        done <= 1'b1;
      end
    end
  end

endmodule
